fp_norm28: RTL and testbench
============================

# fp_norm28

Post-addition normalizer for the 28-bit floating-point mantissa datapath. It consumes the `{COUT, SUM}` result of the 28-bit Kogge-Stone mantissa adder and its working exponent. It renormalizes the mantissa so the leading one sits at bit 27, and adjusts the exponent. It is a 2-stage valid/ready pipeline between the adder output register and the rounding stage.

## Interface
- `EXP_W`, 8, exponent width; exponent max is `2^EXP_W-1`.

- `CLK` in 1: single clock, rising edge.
- `RST_N` in 1: reset, synchronous, active-low.
- `IN_VALID` in 1: input beat valid.
- `IN_READY` out 1: block accepts a beat this cycle.
- `SUM` in 28: adder sum.
- `COUT` in 1: adder carry-out.
- `EXP` in EXP_W: biased exponent of the sum.
- `OUT_VALID` out 1: result valid.
- `OUT_READY` in 1: downstream accepts the result.
- `MANT` out 28: normalized mantissa.
- `EXP_OUT` out EXP_W: adjusted exponent.
- `ZERO` out 1: result is exactly zero.
- `UNF` out 1: normalization limited by the exponent (denormal).
- `OVF` out 1: exponent overflow.

## Operation
- A beat is accepted on a rising edge where `IN_VALID && IN_READY`.
- **Stage 1 (S1):** registers `SUM`, `COUT` and `EXP`, and computes `lzc = LZC(SUM)` in the range 0..28.
- **Stage 2:** computes the result into the output register.
- **Case `COUT=1`:**
  - `MANT = {1'b1, SUM[27:1]}`, with sticky handling per Configuration.
  - `EXP_OUT = EXP+1`.
  - If `EXP == 2^EXP_W-2` or larger: `OVF=1`, `EXP_OUT` = max, `MANT=0`.
- **Case `COUT=0` and `SUM==0`:** `ZERO=1`, `MANT=0`, `EXP_OUT=0`; UNF and OVF are 0.
- **Case `COUT=0` and `SUM!=0`:**
  - `sh = min(lzc, EXP)`.
  - `MANT = SUM << sh`.
  - `EXP_OUT = EXP - sh`.
  - `UNF = (lzc > EXP)`.
- Flags are mutually exclusive.
- **Pipeline occupancy:** S1 and the output register each hold at most one beat. Capacity is 2 and throughput is 1 beat/cycle.
- **Advance rules:**
  - The output register loads when `!OUT_VALID || OUT_READY`.
  - S1 advances into it under the same condition.
  - `IN_READY = RST_N && (!s1_valid || !OUT_VALID || OUT_READY)`. This is combinational from state and `OUT_READY` only; there is no path from `IN_VALID`.
- **Stall:** when `OUT_VALID && !OUT_READY`, `MANT`, `EXP_OUT` and all flags hold stable.
- **Ordering:** beats are never dropped or reordered.

## Timing
- **Reset** (`RST_N` low at an edge): S1 and the output register are cleared to 0. After that edge `OUT_VALID`, `MANT`, `EXP_OUT`, `ZERO`, `UNF` and `OVF` are all 0, and `IN_READY=0` while `RST_N` is low.
- **Reset mid-operation:** all in-flight beats are discarded and the next-edge state is empty.
- **Latency:** a beat accepted at edge k appears on the outputs after edge k+1, provided the output register is free.
- **Simultaneous pop and push:** with `OUT_READY=1`, S1 moves to the output register and a new beat enters S1 on the same edge.
- **Back-to-back stall:** when full and stalled, `IN_READY=0` until `OUT_READY` is asserted. `IN_READY` rises in the same cycle `OUT_READY` rises.

## Configuration
- **`FPN_STICKY_EN` defined:** on a right shift (`COUT=1`), the dropped `SUM[0]` is ORed into `MANT[0]`.
- **`FPN_STICKY_EN` undefined:** the dropped bit is discarded (truncation).
- Left shifts are unaffected either way.

## Structure
- **Shared package `fpn_pkg`:**
  - `MANT_W=28`
  - `LZC_W=5`
  - LZC-result typedef
  - flags struct typedef `{zero, unf, ovf}`
- **Sub-module `lzc28`:** combinational leading-zero counter returning 28 for all-zero input. It is instantiated in stage 1.
- Handshake control and shifter stay in the top module.

## Test plan
1. `COUT=1`, `SUM=28'h0000001`, `EXP=100` -> `EXP_OUT=101`. `MANT=28'h8000001` with `FPN_STICKY_EN`, `28'h8000000` without; no flags.
2. `COUT=0`, `SUM=28'h0001000`, `EXP=100` -> `lzc=15`, `MANT=28'h8000000`, `EXP_OUT=85`, no flags; output 2 edges after acceptance.
3. `COUT=0`, `SUM=0`, `EXP=77` -> `ZERO=1`, `MANT=0`, `EXP_OUT=0`.
4. `COUT=0`, `SUM=28'h0000010`, `EXP=10` -> `MANT=28'h0004000`, `EXP_OUT=0`, `UNF=1`. Also `SUM=28'h0000010`, `EXP=23` -> `MANT=28'h8000000`, `EXP_OUT=0`, `UNF=0`.
5. `COUT=1`, `EXP=254` -> `OVF=1`, `EXP_OUT=255`, `MANT=0`.
6. Backpressure: 3 back-to-back beats with `OUT_READY=0` for 4 cycles.
   - `IN_READY` falls after 2 beats accepted; the outputs hold the first result.
   - Releasing `OUT_READY` delivers all 3 beats in order.
   - Asserting `RST_N=0` mid-stall -> `OUT_VALID=0` after the next edge and no stale beat afterwards.

Source files
------------

// File: rtl/fpn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpn_pkg
// Description : Shared widths and types for the 28-bit mantissa normalizer.
// Revision    : 1.0 - initial release
// ============================================================================
package fpn_pkg;

    localparam int MANT_W = 28;
    localparam int LZC_W  = 5;

    typedef logic [LZC_W-1:0] lzc_t;

    typedef struct packed {
        logic zero;
        logic unf;
        logic ovf;
    } flags_t;

endpackage
`default_nettype wire

// File: rtl/lzc28.sv
`default_nettype none
// ============================================================================
// Module      : lzc28
// Description : Combinational leading-zero counter, returns 28 for all zeros.
// Revision    : 1.0 - initial release
// ============================================================================
module lzc28
    import fpn_pkg::*;
(
    input  logic [MANT_W-1:0] din,
    output lzc_t              count
);

    // Ascending scan so the most significant set bit is the last to win.
    always_comb begin
        count = lzc_t'(MANT_W);
        for (int i = 0; i < MANT_W; i++) begin
            if (din[i]) begin
                count = lzc_t'(MANT_W - 1 - i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_norm28.sv
`default_nettype none
// ============================================================================
// Module      : fp_norm28
// Description : 2-stage valid/ready post-addition normalizer for the 28-bit
//               mantissa path. Optional macro FPN_STICKY_EN keeps the bit
//               dropped by the carry-out right shift as a sticky bit.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_norm28
    import fpn_pkg::*;
#(
    parameter int EXP_W = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [MANT_W-1:0] SUM,
    input  logic              COUT,
    input  logic [EXP_W-1:0]  EXP,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [MANT_W-1:0] MANT,
    output logic [EXP_W-1:0]  EXP_OUT,
    output logic              ZERO,
    output logic              UNF,
    output logic              OVF
);

    localparam logic [EXP_W-1:0] c_EXP_MAX = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] c_EXP_OVF = {{(EXP_W-1){1'b1}}, 1'b0};

    logic              r_s1_valid;
    logic [MANT_W-1:0] r_s1_sum;
    logic              r_s1_cout;
    logic [EXP_W-1:0]  r_s1_exp;
    lzc_t              r_s1_lzc;

    logic              r_out_valid;
    logic [MANT_W-1:0] r_mant;
    logic [EXP_W-1:0]  r_exp;
    flags_t            r_flags;

    lzc_t              w_lzc;
    logic              w_adv;
    logic              w_push;
    lzc_t              w_sh;
    logic [MANT_W-1:0] w_mant;
    logic [EXP_W-1:0]  w_exp;
    flags_t            w_flags;
    logic [EXP_W-1:0]  w_lzc_ext;

    lzc28 u_lzc (
        .din   (SUM),
        .count (w_lzc)
    );

    assign w_adv    = !r_out_valid || OUT_READY;
    assign IN_READY = RST_N && (!r_s1_valid || w_adv);
    assign w_push   = IN_VALID && IN_READY;

    assign w_lzc_ext = EXP_W'(r_s1_lzc);

    always_comb begin
        w_mant  = '0;
        w_exp   = '0;
        w_flags = '0;
        w_sh    = '0;
        if (r_s1_cout) begin
            if (r_s1_exp >= c_EXP_OVF) begin
                w_flags.ovf = 1'b1;
                w_exp       = c_EXP_MAX;
            end else begin
`ifdef FPN_STICKY_EN
                w_mant = {1'b1, r_s1_sum[MANT_W-1:2], r_s1_sum[1] | r_s1_sum[0]};
`else
                w_mant = {1'b1, r_s1_sum[MANT_W-1:1]};
`endif
                w_exp  = r_s1_exp + EXP_W'(1);
            end
        end else if (r_s1_sum == '0) begin
            w_flags.zero = 1'b1;
        end else begin
            // Exponent runs out before the leading one reaches the top: denormal.
            if (w_lzc_ext > r_s1_exp) begin
                w_sh        = r_s1_exp[LZC_W-1:0];
                w_flags.unf = 1'b1;
            end else begin
                w_sh = r_s1_lzc;
            end
            w_mant = r_s1_sum << w_sh;
            w_exp  = r_s1_exp - EXP_W'(w_sh);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_s1_valid  <= 1'b0;
            r_s1_sum    <= '0;
            r_s1_cout   <= 1'b0;
            r_s1_exp    <= '0;
            r_s1_lzc    <= '0;
            r_out_valid <= 1'b0;
            r_mant      <= '0;
            r_exp       <= '0;
            r_flags     <= '0;
        end else begin
            if (w_push) begin
                r_s1_valid <= 1'b1;
                r_s1_sum   <= SUM;
                r_s1_cout  <= COUT;
                r_s1_exp   <= EXP;
                r_s1_lzc   <= w_lzc;
            end else if (w_adv) begin
                r_s1_valid <= 1'b0;
            end
            if (w_adv) begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_mant  <= w_mant;
                    r_exp   <= w_exp;
                    r_flags <= w_flags;
                end
            end
        end
    end

    assign OUT_VALID = r_out_valid;
    assign MANT      = r_mant;
    assign EXP_OUT   = r_exp;
    assign ZERO      = r_flags.zero;
    assign UNF       = r_flags.unf;
    assign OVF       = r_flags.ovf;

endmodule
`default_nettype wire

// File: tb/tb_fp_norm28.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_norm28
// Description : Directed self-checking bench for fp_norm28.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_norm28;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        IN_VALID;
    logic        IN_READY;
    logic [27:0] SUM;
    logic        COUT;
    logic [7:0]  EXP;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [27:0] MANT;
    logic [7:0]  EXP_OUT;
    logic        ZERO;
    logic        UNF;
    logic        OVF;

    int vectors     = 0;
    int miscompares = 0;

    fp_norm28 #(.EXP_W(8)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .SUM       (SUM),
        .COUT      (COUT),
        .EXP       (EXP),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .MANT      (MANT),
        .EXP_OUT   (EXP_OUT),
        .ZERO      (ZERO),
        .UNF       (UNF),
        .OVF       (OVF)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [27:0] m, input logic [7:0] e,
                             input logic z, input logic u, input logic o);
        check({tag, ".valid"}, 32'(OUT_VALID), 32'd1);
        check({tag, ".mant"},  32'(MANT), 32'(m));
        check({tag, ".exp"},   32'(EXP_OUT), 32'(e));
        check({tag, ".flags"}, 32'({ZERO, UNF, OVF}), 32'({z, u, o}));
    endtask

    // Single beat with a free output register: visible after the second edge.
    task automatic one_beat(input logic c, input logic [27:0] s, input logic [7:0] e);
        COUT = c; SUM = s; EXP = e; IN_VALID = 1'b1;
        step();
        IN_VALID = 1'b0;
        check("latency", 32'(OUT_VALID), 32'd0);
        step();
    endtask

    localparam logic [27:0] T1_MANT =
`ifdef FPN_STICKY_EN
        28'h8000001;
`else
        28'h8000000;
`endif

    initial begin
        RST_N = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
        SUM = '0; COUT = 1'b0; EXP = '0;
        step(); step();
        check("rst.out_valid", 32'(OUT_VALID), 32'd0);
        check("rst.in_ready",  32'(IN_READY), 32'd0);
        check("rst.mant",      32'(MANT), 32'd0);
        check("rst.exp",       32'(EXP_OUT), 32'd0);
        check("rst.flags",     32'({ZERO, UNF, OVF}), 32'd0);
        RST_N = 1'b1;
        #1;
        check("rel.in_ready", 32'(IN_READY), 32'd1);

        one_beat(1'b1, 28'h0000001, 8'd100);
        check_out("t1", T1_MANT, 8'd101, 1'b0, 1'b0, 1'b0);
        one_beat(1'b0, 28'h0001000, 8'd100);
        check_out("t2", 28'h8000000, 8'd85, 1'b0, 1'b0, 1'b0);
        one_beat(1'b0, 28'h0000000, 8'd77);
        check_out("t3", 28'h0000000, 8'd0, 1'b1, 1'b0, 1'b0);
        one_beat(1'b0, 28'h0000010, 8'd10);
        check_out("t4a", 28'h0004000, 8'd0, 1'b0, 1'b1, 1'b0);
        one_beat(1'b0, 28'h0000010, 8'd23);
        check_out("t4b", 28'h8000000, 8'd0, 1'b0, 1'b0, 1'b0);
        one_beat(1'b1, 28'h0000001, 8'd254);
        check_out("t5", 28'h0000000, 8'd255, 1'b0, 1'b0, 1'b1);
        one_beat(1'b1, 28'hFFFFFFF, 8'd253);
        check_out("t5b", 28'hFFFFFFF, 8'd254, 1'b0, 1'b0, 1'b0);
        one_beat(1'b0, 28'h8000000, 8'd0);
        check_out("t5c", 28'h8000000, 8'd0, 1'b0, 1'b0, 1'b0);
        one_beat(1'b0, 28'h4000000, 8'd0);
        check_out("t5d", 28'h4000000, 8'd0, 1'b0, 1'b1, 1'b0);

        // Backpressure: A, B accepted, C blocked while the output stalls.
        step();
        OUT_READY = 1'b0;
        COUT = 1'b0; SUM = 28'h0001000; EXP = 8'd100; IN_VALID = 1'b1;
        #1;
        check("bp.rdyA", 32'(IN_READY), 32'd1);
        step();
        COUT = 1'b1; SUM = 28'h0000002; EXP = 8'd50;
        #1;
        check("bp.rdyB", 32'(IN_READY), 32'd1);
        step();
        COUT = 1'b0; SUM = 28'h0000010; EXP = 8'd23;
        #1;
        check("bp.rdyC", 32'(IN_READY), 32'd0);
        check_out("bp.holdA0", 28'h8000000, 8'd85, 1'b0, 1'b0, 1'b0);
        step();
        check("bp.rdyC1", 32'(IN_READY), 32'd0);
        check_out("bp.holdA1", 28'h8000000, 8'd85, 1'b0, 1'b0, 1'b0);
        step();
        check_out("bp.holdA2", 28'h8000000, 8'd85, 1'b0, 1'b0, 1'b0);
        OUT_READY = 1'b1;
        #1;
        check("bp.rdy_rise", 32'(IN_READY), 32'd1);
        step();
        IN_VALID = 1'b0;
        check_out("bp.B", 28'h8000001, 8'd51, 1'b0, 1'b0, 1'b0);
        step();
        check_out("bp.C", 28'h8000000, 8'd0, 1'b0, 1'b0, 1'b0);
        step();
        check("bp.drained", 32'(OUT_VALID), 32'd0);

        // Reset while full and stalled discards both beats.
        OUT_READY = 1'b0;
        COUT = 1'b0; SUM = 28'h0001000; EXP = 8'd100; IN_VALID = 1'b1;
        step();
        COUT = 1'b1; SUM = 28'h0000002; EXP = 8'd50;
        step();
        IN_VALID = 1'b0;
        check("mr.full", 32'(OUT_VALID), 32'd1);
        RST_N = 1'b0;
        #1;
        check("mr.in_ready", 32'(IN_READY), 32'd0);
        step();
        check("mr.out_valid", 32'(OUT_VALID), 32'd0);
        check("mr.mant", 32'(MANT), 32'd0);
        RST_N = 1'b1; OUT_READY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("mr.no_stale", 32'(OUT_VALID), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
